// File: rtl/gps_acq_pkg.sv
// Shared types and constants for the C/A-code acquisition engine.
package gps_acq_pkg;

    localparam int unsigned CODE_LEN = 1023;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        SLIP,
        DONE
    } acq_state_e;

    // G2 stage numbers (1..10) whose XOR forms the PRN-specific G2 delay
    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
    } g2_taps_t;

    function automatic logic prn_ok(input logic [5:0] prn);
        return (prn >= 6'd1) && (prn <= 6'd32);
    endfunction

    // ICD-GPS-200 code phase assignments; out-of-range PRNs get a harmless pair
    function automatic g2_taps_t prn_taps(input logic [5:0] prn);
        g2_taps_t t;
        t = '{4'd1, 4'd1};
        case (prn)
            6'd1:  t = '{4'd2, 4'd6};
            6'd2:  t = '{4'd3, 4'd7};
            6'd3:  t = '{4'd4, 4'd8};
            6'd4:  t = '{4'd5, 4'd9};
            6'd5:  t = '{4'd1, 4'd9};
            6'd6:  t = '{4'd2, 4'd10};
            6'd7:  t = '{4'd1, 4'd8};
            6'd8:  t = '{4'd2, 4'd9};
            6'd9:  t = '{4'd3, 4'd10};
            6'd10: t = '{4'd2, 4'd3};
            6'd11: t = '{4'd3, 4'd4};
            6'd12: t = '{4'd5, 4'd6};
            6'd13: t = '{4'd6, 4'd7};
            6'd14: t = '{4'd7, 4'd8};
            6'd15: t = '{4'd8, 4'd9};
            6'd16: t = '{4'd9, 4'd10};
            6'd17: t = '{4'd1, 4'd4};
            6'd18: t = '{4'd2, 4'd5};
            6'd19: t = '{4'd3, 4'd6};
            6'd20: t = '{4'd4, 4'd7};
            6'd21: t = '{4'd5, 4'd8};
            6'd22: t = '{4'd6, 4'd9};
            6'd23: t = '{4'd1, 4'd3};
            6'd24: t = '{4'd4, 4'd6};
            6'd25: t = '{4'd5, 4'd7};
            6'd26: t = '{4'd6, 4'd8};
            6'd27: t = '{4'd7, 4'd9};
            6'd28: t = '{4'd8, 4'd10};
            6'd29: t = '{4'd1, 4'd6};
            6'd30: t = '{4'd2, 4'd7};
            6'd31: t = '{4'd3, 4'd8};
            6'd32: t = '{4'd4, 4'd9};
            default: t = '{4'd1, 4'd1};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/gps_ca_acq_if.sv
// Control, chip-stream and result signals of the acquisition engine.
interface gps_ca_acq_if;
    logic [5:0] sv_num;
    logic       start;
    logic       chip_in;
    logic       chip_valid;
    logic       busy;
    logic       acq_done;
    logic       acq_hit;
    logic [9:0] code_phase;
    logic [9:0] peak_count;
    logic       prn_err;

    modport master (
        output sv_num, start, chip_in, chip_valid,
        input  busy, acq_done, acq_hit, code_phase, peak_count, prn_err
    );

    modport slave (
        input  sv_num, start, chip_in, chip_valid,
        output busy, acq_done, acq_hit, code_phase, peak_count, prn_err
    );
endinterface

// File: rtl/ca_replica.sv
// Local C/A replica: G1/G2 LFSRs, stages numbered 1..10 as in the ICD.
module ca_replica
    import gps_acq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load_i,
    input  g2_taps_t taps_i,
    input  logic     adv_i,
    output logic     chip_o
);

    logic [10:1] g1_q;
    logic [10:1] g2_q;
    logic        g1_fb;
    logic        g2_fb;

    assign g1_fb  = g1_q[3] ^ g1_q[10];
    assign g2_fb  = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];
    assign chip_o = g1_q[10] ^ g2_q[taps_i.s1] ^ g2_q[taps_i.s2];

    // Load to all-ones on request, otherwise shift toward stage 10 on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1_q <= '1;
            g2_q <= '1;
        end else if (load_i) begin
            g1_q <= '1;
            g2_q <= '1;
        end else if (adv_i) begin
            g1_q <= {g1_q[9:1], g1_fb};
            g2_q <= {g2_q[9:1], g2_fb};
        end
    end

endmodule

// File: rtl/gps_ca_acq.sv
// Serial code-phase search: one 1023-chip dwell per phase, one slipped chip between dwells.
module gps_ca_acq
    import gps_acq_pkg::*;
#(
    parameter logic [9:0]  THRESH    = 10'd800,
    parameter int unsigned MAX_PHASE = 1023
) (
    input logic         clk,
    input logic         rst,
    gps_ca_acq_if.slave acq
);

    localparam logic [9:0] LAST_IDX   = 10'(CODE_LEN - 1);
    localparam logic [9:0] LAST_PHASE = 10'(MAX_PHASE - 1);

    acq_state_e state_q, state_d;
    g2_taps_t   taps_q, taps_d;
    logic [9:0] count_q, count_d;
    logic [9:0] idx_q, idx_d;
    logic [9:0] phase_q, phase_d;
    logic [9:0] peak_q, peak_d;
    logic [9:0] cphase_q, cphase_d;
    logic       hit_q, hit_d;
    logic       perr_q, perr_d;

    logic       load;
    logic       adv;
    logic       rep_chip;
    logic       agree;
    logic [9:0] final_cnt;

    ca_replica u_replica (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .taps_i (taps_q),
        .adv_i  (adv),
        .chip_o (rep_chip)
    );

    // Next-state logic: dwell bookkeeping, peak tracking and hit/miss decision
    always_comb begin
        state_d   = state_q;
        taps_d    = taps_q;
        count_d   = count_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        peak_d    = peak_q;
        cphase_d  = cphase_q;
        hit_d     = hit_q;
        perr_d    = perr_q;
        load      = 1'b0;
        adv       = 1'b0;
        agree     = (acq.chip_in == rep_chip);
        final_cnt = count_q + {9'd0, agree};

        case (state_q)
            IDLE: begin
                if (acq.start) begin
                    taps_d   = prn_taps(acq.sv_num);
                    hit_d    = 1'b0;
                    cphase_d = '0;
                    peak_d   = '0;
                    perr_d   = 1'b0;
                    phase_d  = '0;
                    count_d  = '0;
                    idx_d    = '0;
                    if (!prn_ok(acq.sv_num)) begin
                        perr_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (acq.chip_valid) begin
                    adv = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // strict compare keeps the earliest phase on ties
                        if (final_cnt > peak_q) begin
                            peak_d   = final_cnt;
                            cphase_d = phase_q;
                        end
                        if (final_cnt >= THRESH) begin
                            hit_d   = 1'b1;
                            state_d = DONE;
                        end else if (phase_q == LAST_PHASE) begin
                            state_d = DONE;
                        end else begin
                            state_d = SLIP;
                        end
                    end else begin
                        count_d = final_cnt;
                        idx_d   = idx_q + 10'd1;
                    end
                end
            end
            SLIP: begin
                // replica holds while one received chip is dropped
                if (acq.chip_valid) begin
                    phase_d = phase_q + 10'd1;
                    count_d = '0;
                    idx_d   = '0;
                    state_d = SEARCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            taps_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            phase_q  <= '0;
            peak_q   <= '0;
            cphase_q <= '0;
            hit_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            taps_q   <= taps_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            peak_q   <= peak_d;
            cphase_q <= cphase_d;
            hit_q    <= hit_d;
            perr_q   <= perr_d;
        end
    end

    assign acq.busy       = (state_q != IDLE);
    assign acq.acq_done   = (state_q == DONE);
    assign acq.acq_hit    = hit_q;
    assign acq.code_phase = cphase_q;
    assign acq.peak_count = peak_q;
    assign acq.prn_err    = perr_q;

endmodule

// File: tb/tb_gps_ca_acq.sv
// Bench for gps_ca_acq: table of searches against a chip-level search model.
module tb_gps_ca_acq;

    localparam int MAXP  = 8;
    localparam int THR   = 800;
    localparam int NCHIP = 9000;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gps_ca_acq_if bus ();

    gps_ca_acq #(
        .THRESH    (10'd800),
        .MAX_PHASE (MAXP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .acq (bus)
    );

    int tests = 0;
    int fails = 0;

    int tap1 [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap2 [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    bit ca [1:32][0:1022];
    bit stream [0:NCHIP-1];

    typedef struct {
        int sv;
        int feed;
        int delay;
        int flip_pct;
        int valid_pct;
        bit disturb;
        bit use_model;
        bit exp_err;
        bit exp_hit;
        int exp_phase;
        int exp_peak;
        int exp_chips;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Gold codes generated stage by stage from the ICD shift-register description
    task automatic build_codes();
        int g1 [1:10];
        int g2 [1:10];
        int f1, f2;
        for (int p = 1; p <= 32; p++) begin
            for (int s = 1; s <= 10; s++) begin
                g1[s] = 1;
                g2[s] = 1;
            end
            for (int n = 0; n < 1023; n++) begin
                ca[p][n] = 1'(g1[10] ^ g2[tap1[p]] ^ g2[tap2[p]]);
                f1 = g1[3] ^ g1[10];
                f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
                for (int s = 10; s >= 2; s--) begin
                    g1[s] = g1[s-1];
                    g2[s] = g2[s-1];
                end
                g1[1] = f1;
                g2[1] = f2;
            end
        end
    endtask

    task automatic fill_stream(input int feed, input int delay, input int flip_pct);
        for (int k = 0; k < NCHIP; k++) begin
            bit b;
            if (feed == 0) b = 1'($urandom_range(0, 1));
            else           b = ca[feed][(k + 1023 - delay) % 1023];
            if (int'($urandom_range(0, 99)) < flip_pct) b = ~b;
            stream[k] = b;
        end
    endtask

    // Dwell d compares r[k] with c[(k-d) mod 1023] for k = 1024d .. 1024d+1022
    function automatic void model(input int prn, output bit hit, output int phase,
                                  output int peak, output int chips);
        hit = 0; phase = 0; peak = 0; chips = 0;
        for (int d = 0; d < MAXP; d++) begin
            int agree;
            agree = 0;
            for (int j = 0; j < 1023; j++) begin
                int k;
                k = 1024 * d + j;
                if (stream[k] == ca[prn][(k - d) % 1023]) agree++;
            end
            if (agree > peak) begin
                peak  = agree;
                phase = d;
            end
            chips = 1024 * d + 1023;
            if (agree >= THR) begin
                hit = 1;
                return;
            end
        end
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        int  k, cyc;
        bit  seen;
        bus.sv_num     = 6'(v.sv);
        bus.start      = 1'b1;
        bus.chip_valid = 1'b0;
        bus.chip_in    = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check($sformatf("v%0d_busy_start", i), bus.busy, 1);
        if (!v.exp_err)
            check($sformatf("v%0d_peak_cleared", i), bus.peak_count, 0);
        k = 0; cyc = 0; seen = 0;
        while (!seen && cyc < LIMIT) begin
            if (bus.acq_done) begin
                seen = 1;
            end else begin
                if (v.disturb) begin
                    bus.start  = 1'($urandom_range(0, 1));
                    bus.sv_num = 6'($urandom_range(0, 63));
                end
                bus.chip_valid = (int'($urandom_range(0, 99)) < v.valid_pct);
                bus.chip_in    = (bus.chip_valid && k < NCHIP) ? stream[k] : 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                if (bus.chip_valid) k++;
                cyc++;
            end
        end
        bus.start      = 1'b0;
        bus.chip_valid = 1'b0;
        check($sformatf("v%0d_done_seen", i), seen, 1);
        check($sformatf("v%0d_chips", i), k, v.exp_chips);
        check($sformatf("v%0d_busy_done", i), bus.busy, 1);
        check($sformatf("v%0d_hit", i), bus.acq_hit, v.exp_hit);
        check($sformatf("v%0d_phase", i), bus.code_phase, v.exp_phase);
        check($sformatf("v%0d_peak", i), bus.peak_count, v.exp_peak);
        check($sformatf("v%0d_prn_err", i), bus.prn_err, v.exp_err);
        @(posedge clk); #1;
        check($sformatf("v%0d_done_pulse", i), bus.acq_done, 0);
        check($sformatf("v%0d_idle", i), bus.busy, 0);
        check($sformatf("v%0d_phase_hold", i), bus.code_phase, v.exp_phase);
        check($sformatf("v%0d_peak_hold", i), bus.peak_count, v.exp_peak);
    endtask

    initial begin
        logic [9:0] head;
        bit         mh;
        int         mp, mk, mc;
        bit         done_in_rst;

        rst            = 1'b1;
        bus.sv_num     = '0;
        bus.start      = 1'b0;
        bus.chip_in    = 1'b0;
        bus.chip_valid = 1'b0;
        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.acq_done, 0);
        check("rst_hit", bus.acq_hit, 0);
        check("rst_phase", bus.code_phase, 0);
        check("rst_peak", bus.peak_count, 0);
        check("rst_prn_err", bus.prn_err, 0);

        build_codes();
        for (int n = 0; n < 10; n++) head[9-n] = ca[1][n];
        check("model_prn1_head", head, 10'b1100100000);

        // inputs first, expectations either fixed by the search rules or from the model
        vecs[0] = '{1, 1, 0, 0, 100, 0, 0, 0, 1, 0, 1023, 1023};
        vecs[1] = '{7, 7, 5, 0, 50, 0, 0, 0, 1, 5, 1023, 6143};
        vecs[2] = '{3, 9, 0, 0, 100, 0, 1, 0, 0, 0, 0, 8191};
        vecs[3] = '{0, 1, 0, 0, 100, 0, 0, 1, 0, 0, 0, 0};
        vecs[4] = '{33, 1, 0, 0, 100, 0, 0, 1, 0, 0, 0, 0};
        vecs[5] = '{11, 11, 1, 0, 100, 1, 0, 0, 1, 1, 1023, 2047};
        for (int i = 6; i < 8; i++) begin
            vecs[i] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
            vecs[i].sv        = int'($urandom_range(1, 32));
            vecs[i].feed      = vecs[i].sv;
            vecs[i].delay     = int'($urandom_range(0, MAXP - 1));
            vecs[i].flip_pct  = int'($urandom_range(0, 15));
            vecs[i].valid_pct = int'($urandom_range(60, 100));
        end
        vecs[8] = '{0, 0, 0, 0, 75, 0, 1, 0, 0, 0, 0, 0};
        vecs[8].sv = int'($urandom_range(1, 32));

        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            fill_stream(vecs[i].feed, vecs[i].delay, vecs[i].flip_pct);
            if (vecs[i].use_model) begin
                model(vecs[i].sv, mh, mp, mk, mc);
                vecs[i].exp_hit   = mh;
                vecs[i].exp_phase = mp;
                vecs[i].exp_peak  = mk;
                vecs[i].exp_chips = mc;
            end
            run_vec(i, vecs[i]);
            @(posedge clk); #1;
        end

        // start held through the DONE cycle is only taken once back in IDLE
        bus.sv_num = 6'd33;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        check("dstart_first_done", bus.acq_done, 1);
        @(posedge clk); #1;
        check("dstart_idle_gap", bus.acq_done, 0);
        check("dstart_idle_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("dstart_second_done", bus.acq_done, 1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("dstart_end_busy", bus.busy, 0);

        // asynchronous reset in the second dwell, after a peak has been recorded
        fill_stream(0, 0, 0);
        bus.sv_num = 6'd2;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        mc = 0;
        for (int c = 0; c < 2400; c++) begin
            bus.chip_valid = c[0];
            bus.chip_in    = stream[mc];
            @(posedge clk); #1;
            if (bus.chip_valid) mc++;
        end
        check("prerst_peak_set", (bus.peak_count != 0), 1);
        check("prerst_busy", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.acq_done, 0);
        check("midrst_hit", bus.acq_hit, 0);
        check("midrst_phase", bus.code_phase, 0);
        check("midrst_peak", bus.peak_count, 0);
        check("midrst_prn_err", bus.prn_err, 0);
        done_in_rst = 0;
        for (int c = 0; c < 6; c++) begin
            bus.chip_valid = ~bus.chip_valid;
            @(posedge clk); #1;
            if (bus.acq_done) done_in_rst = 1;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.chip_valid = ~bus.chip_valid;
            @(posedge clk); #1;
            if (bus.acq_done) done_in_rst = 1;
        end
        bus.chip_valid = 1'b0;
        check("rst_no_done_pulse", done_in_rst, 0);
        check("postrst_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gps_ca_acq.md
# gps_ca_acq

Receiver-side C/A-code acquisition engine: the counterpart to the GPS transmitter's C/A code generator. It takes a received C/A chip stream for one satellite and runs a serial code-phase search. A local replica for the selected PRN is correlated against the stream one 1023-chip dwell at a time, slipping the replica one chip per dwell. It reports the first code phase whose agreement count reaches a threshold, or the best phase found if none does.

## Interface

Parameters:
- THRESH, 10'd800: agreement count (0..1023) at which a dwell is declared a hit.
- MAX_PHASE, 1023: number of code phases searched (1..1023).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sv_num  in  6  PRN to search; sampled only when start is accepted.
- start  in  1  begin a search; accepted only in IDLE.
- chip_in  in  1  received chip.
- chip_valid  in  1  chip_in qualifier; no backpressure.
- busy  out  1  high from the start-accept edge until the DONE cycle ends.
- acq_done  out  1  one-cycle pulse; result outputs are valid from this cycle onward.
- acq_hit  out  1  the search ended on a threshold hit.
- code_phase  out  10  phase of the hit, or of the best peak.
- peak_count  out  10  largest dwell agreement count seen.
- prn_err  out  1  sv_num was outside 1..32 at start.

## Operation

- Reset values: all outputs 0, FSM IDLE, replica loaded all-ones.
- FSM states:
  - IDLE: on start, latch sv_num and clear acq_hit, code_phase, peak_count, prn_err and the internal phase/count/chip index.
    - If sv_num is outside 1..32: set prn_err and go to DONE.
    - Otherwise: load the replica (G1 = G2 = 10'h3FF) and go to SEARCH.
  - SEARCH: on each valid chip, count the chip as an agreement if chip_in equals the replica chip, then advance the replica.
    - On the 1023rd chip of the dwell, compute final = count + this chip's agreement, combinationally in the same cycle.
    - If final > peak_count: peak_count ← final, code_phase ← phase. On ties the earlier phase is kept.
    - If final ≥ THRESH: acq_hit ← 1 and go to DONE.
    - Else, if phase == MAX_PHASE-1: go to DONE.
    - Else: go to SLIP.
  - SLIP: the next valid chip is discarded and the replica holds. Then phase++, count ← 0, go to SEARCH.
  - DONE: acq_done = 1 for this one cycle, then go to IDLE.
- Phase definition: during dwell d, received chip r[k] (k = valid-chip index after start, from 0) is compared with c[(k−d) mod 1023]. This holds because each dwell spans 1024 chips and 1024·d ≡ d (mod 1023).
- Replica chip rules:
  - G1 feedback taps: 3, 10.
  - G2 feedback taps: 2, 3, 6, 8, 9, 10.
  - Output chip = G1[10] ^ G2[s1] ^ G2[s2], with (s1, s2) per PRN from the standard ICD-GPS-200 table.
- Counters: count and peak_count are 10 bits (maximum value 1023, no overflow); phase is 10 bits.
- Boundary conditions:
  - start while busy: ignored.
  - chip_valid low: all state holds; gaps are allowed anywhere, including in SLIP.
  - sv_num changes mid-search: ignored, because the value was latched at start.
  - rst mid-search: immediate return to reset values; acq_done does not pulse.
  - start in the DONE cycle: ignored; it is accepted from IDLE on the next cycle.

## Timing

- start sampled high in IDLE at edge E0: busy is high from E0.
- prn_err path: DONE is the cycle after E0, so acq_done pulses one cycle after start.
- Hit at phase p: the final accepted chip is valid chip number p·1024 + 1023, counted from start. acq_done is high in the cycle following that chip's edge.
- Miss: acq_done follows valid chip number (MAX_PHASE−1)·1024 + 1023.
- acq_hit, code_phase, peak_count and prn_err are registered no later than the acq_done cycle and hold until the next accepted start.

## Structure

- Package gps_acq_pkg holds:
  - CODE_LEN = 1023.
  - The FSM state enum (IDLE, SEARCH, SLIP, DONE).
  - A function mapping PRN 1..32 to its G2 tap pair.
- Sub-module ca_replica holds the G1/G2 LFSRs. Inputs: clk, rst, load, tap pair, adv. Output: chip.
- The top level holds the FSM, counters and result registers.

## Test plan

- Reset: assert rst mid-search with chip_valid toggling → all outputs 0 within the same cycle; no acq_done pulse.
- PRN 1, stream = replica at phase 0, chip_valid always high → acq_done after 1023 valid chips; acq_hit=1, code_phase=0, peak_count=1023.
- PRN 7, stream delayed 5 chips (r[k] = c[(k−5) mod 1023]), chip_valid random at 50% duty → acq_done after valid chip 6143; code_phase=5, peak_count=1023, acq_hit=1.
- MAX_PHASE=8, search PRN 3 while feeding PRN 9 code → acq_done after valid chip 8191; acq_hit=0, peak_count ≤ 543, code_phase in 0..7.
- sv_num=0 or 33 at start → prn_err=1 and acq_done one cycle after start; busy lasts 1 cycle; no chips consumed.
- Second start pulse while busy, and sv_num changed mid-search → no effect; results match the original PRN and timing.
